// File: rtl/second_layer_rospine.sv
// second_layer_rospine: sequential XNOR-popcount output layer, argmax over CLASS_CNT weight rows; done CLASS_CNT edges after in_valid.
// No backpressure: result holds in DONE until in_valid drops. Define SECOND_LAYER_SCORE_EN to expose best_score.
module second_layer_rospine #(
  parameter int HIDDEN_CNT = 4,
  parameter int CLASS_CNT  = 3,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights = '0,
  localparam int SW = $clog2(HIDDEN_CNT + 1),
  localparam int CW = $clog2(CLASS_CNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [HIDDEN_CNT-1:0] hidden,
  output logic [CW-1:0]         class_out,
  output logic                  done
`ifdef SECOND_LAYER_SCORE_EN
  , output logic [SW-1:0]       best_score
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         best_idx_q, best_idx_d;
  logic [CW-1:0]         class_q, class_d;
  logic [SW-1:0]         best_score_q, best_score_d;
  logic [HIDDEN_CNT-1:0] hid_q, hid_d;
  logic                  done_q, done_d;
  logic [HIDDEN_CNT-1:0] row;
  logic [SW-1:0]         score;

  always_comb begin
    // Constant-index row mux keeps every select in range for any cnt value.
    row = '0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      if (cnt_q == CW'(c)) row = Weights[c*HIDDEN_CNT +: HIDDEN_CNT];
    end
    score = '0;
    for (int i = 0; i < HIDDEN_CNT; i++) begin
      score = score + SW'(~(hid_q[i] ^ row[i]));
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    hid_d        = hid_q;
    class_d      = class_q;
    done_d       = done_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hid_d        = hidden;
          cnt_d        = '0;
          best_score_d = '0;
          best_idx_d   = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Strict '>' keeps the lowest class index on ties.
        if (cnt_q == '0 || score > best_score_q) begin
          best_score_d = score;
          best_idx_d   = cnt_q;
        end
        if (cnt_q == CW'(CLASS_CNT - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          class_d = best_idx_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!in_valid) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      hid_q        <= '0;
      class_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      hid_q        <= hid_d;
      class_q      <= class_d;
      done_q       <= done_d;
    end
  end

  assign class_out = class_q;
  assign done      = done_q;
`ifdef SECOND_LAYER_SCORE_EN
  assign best_score = best_score_q;
`endif

endmodule
